// File: rtl/key_press_gen_if.sv
// key_press_gen_if: request/status bundle between a press requester and
// the key_press_gen driver. The requester side is "master" and the
// generator side is "slave".
interface key_press_gen_if #(
    parameter int CNT_W = 20
);
    logic             start;     // press request, sampled each clock
    logic [CNT_W-1:0] hold_len;  // press length, 0 selects the default
    logic             key_out;   // active-low key line (1 = released)
    logic             busy;      // press sequence in progress
    logic             done;      // one-cycle completion pulse

    modport master (
        output start,
        output hold_len,
        input  key_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hold_len,
        output key_out,
        output busy,
        output done
    );
endinterface

// File: rtl/key_press_gen.sv
// key_press_gen: drives an active-low key line with one press per accepted
// request: low for L cycles, then released for GAP_TIME cycles, then a
// one-cycle done pulse back in IDLE.
// Optional feature: define KEY_BOUNCE_EN to add contact bounce on both the
// press and release edges (BOUNCE_DN / BOUNCE_UP states). Without it the
// line makes single clean edges and the bounce parameters are unused.
module key_press_gen #(
    parameter int CNT_W         = 20,
    parameter int PRESS_TIME    = 1000,
    parameter int GAP_TIME      = 1000,
    parameter int BOUNCE_GLITCH = 3,
    parameter int BOUNCE_PERIOD = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    key_press_gen_if.slave bus
);

`ifdef KEY_BOUNCE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_BOUNCE_DN, S_HOLD, S_BOUNCE_UP, S_GAP
    } state_t;

    // Each bounced edge is 2*BOUNCE_GLITCH+1 toggles; the last toggle lands
    // on the edge that enters the following steady state.
    localparam int NTRANS = 2 * BOUNCE_GLITCH + 1;
    localparam int BW     = $clog2(NTRANS + 1);
`else
    typedef enum logic [1:0] {
        S_IDLE, S_HOLD, S_GAP
    } state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;     // shared duration counter, cleared per state
    logic [CNT_W-1:0] r_len;     // press length latched at accept
    logic             r_key;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_len_sel;
    logic             w_hold_tc;
    logic             w_gap_tc;

    assign w_len_sel = (bus.hold_len == '0) ? CNT_W'(PRESS_TIME) : bus.hold_len;
    assign w_hold_tc = (r_cnt == r_len - CNT_W'(1));
    assign w_gap_tc  = (r_cnt == CNT_W'(GAP_TIME - 1));

`ifdef KEY_BOUNCE_EN
    logic [BW-1:0]    r_bcnt;    // toggles already made on the current edge
    logic             w_per_tc;
    logic             w_last_tr;

    assign w_per_tc  = (r_cnt == CNT_W'(BOUNCE_PERIOD - 1));
    assign w_last_tr = (r_bcnt == BW'(NTRANS - 1));
`else
    // Bounce parameters are kept in the parameter list for a uniform
    // interface; fold them into an explicitly unused net.
    logic             w_unused_bounce;
    assign w_unused_bounce = ^{BOUNCE_GLITCH, BOUNCE_PERIOD};
`endif

    // Press sequencer: state, counters and every output are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_key   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef KEY_BOUNCE_EN
            r_bcnt  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done cycle is IDLE too, so a start there is accepted
                    if (bus.start) begin
                        r_len  <= w_len_sel;
                        r_key  <= 1'b0;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
`ifdef KEY_BOUNCE_EN
                        r_bcnt <= BW'(1);
                        if (BOUNCE_GLITCH == 0)
                            r_state <= S_HOLD;
                        else
                            r_state <= S_BOUNCE_DN;
`else
                        r_state <= S_HOLD;
`endif
                    end
                end

`ifdef KEY_BOUNCE_EN
                S_BOUNCE_DN: begin
                    if (w_per_tc) begin
                        r_key  <= ~r_key;
                        r_cnt  <= '0;
                        r_bcnt <= r_bcnt + BW'(1);
                        if (w_last_tr)
                            r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif

                S_HOLD: begin
                    if (w_hold_tc) begin
                        r_key <= 1'b1;
                        r_cnt <= '0;
`ifdef KEY_BOUNCE_EN
                        r_bcnt <= BW'(1);
                        if (BOUNCE_GLITCH == 0)
                            r_state <= S_GAP;
                        else
                            r_state <= S_BOUNCE_UP;
`else
                        r_state <= S_GAP;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

`ifdef KEY_BOUNCE_EN
                S_BOUNCE_UP: begin
                    if (w_per_tc) begin
                        r_key  <= ~r_key;
                        r_cnt  <= '0;
                        r_bcnt <= r_bcnt + BW'(1);
                        if (w_last_tr)
                            r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif

                S_GAP: begin
                    if (w_gap_tc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_key   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_out = r_key;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_key_press_gen.sv
// tb_key_press_gen: directed plus random stimulus against a waveform-list
// reference model. On accept the model expands the whole expected press
// (bounce, hold, bounce, gap, done) into a queue of per-cycle outputs.
module tb_key_press_gen;
    localparam int CNT_W = 20;
    localparam int PT    = 8;
    localparam int GT    = 4;
    localparam int BG    = 2;
    localparam int BP    = 2;
`ifdef KEY_BOUNCE_EN
    localparam int G = BG;
`else
    localparam int G = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_press_gen_if #(.CNT_W(CNT_W)) bus ();

    key_press_gen #(
        .CNT_W(CNT_W), .PRESS_TIME(PT), .GAP_TIME(GT),
        .BOUNCE_GLITCH(BG), .BOUNCE_PERIOD(BP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // expected {key_out, busy, done} per cycle
    logic [2:0] q[$];
    logic [2:0] exp_o = 3'b100;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic void gen_press(input int len);
        for (int k = 0; k < 2 * G; k++)
            for (int j = 0; j < BP; j++) q.push_back({(k % 2 == 0) ? 1'b0 : 1'b1, 2'b10});
        for (int j = 0; j < len; j++) q.push_back(3'b010);
        for (int k = 0; k < 2 * G; k++)
            for (int j = 0; j < BP; j++) q.push_back({(k % 2 == 0) ? 1'b1 : 1'b0, 2'b10});
        for (int j = 0; j < GT; j++) q.push_back(3'b110);
        q.push_back(3'b101);
    endfunction

    task automatic check_outputs();
        n_cmp++;
        assert (bus.key_out === exp_o[2]) else begin
            n_err++;
            $error("FAIL key_out cyc=%0d got=%b exp=%b", cyc, bus.key_out, exp_o[2]);
        end
        n_cmp++;
        assert (bus.busy === exp_o[1]) else begin
            n_err++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_o[1]);
        end
        n_cmp++;
        assert (bus.done === exp_o[0]) else begin
            n_err++;
            $error("FAIL done cyc=%0d got=%b exp=%b", cyc, bus.done, exp_o[0]);
        end
    endtask

    // one clock: drive inputs on negedge, advance model at posedge, check after
    task automatic step(input logic s, input logic [CNT_W-1:0] hl, input logic r);
        @(negedge clk);
        bus.start    = s;
        bus.hold_len = hl;
        rst          = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            exp_o = 3'b100;
        end else begin
            if (q.size() == 0 && s) gen_press((hl == '0) ? PT : int'(hl));
            if (q.size() > 0) exp_o = q.pop_front();
            else              exp_o = 3'b100;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // run idle until the model expects done, bounded
    task automatic run_to_done();
        int i;
        i = 0;
        while (!exp_o[0] && i < 300) begin
            step(1'b0, '0, 1'b0);
            i++;
        end
        n_cmp++;
        assert (exp_o[0] === 1'b1 && bus.done === 1'b1) else begin
            n_err++;
            $error("FAIL done_wait cyc=%0d got=%b exp=1", cyc, bus.done);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.hold_len = '0;

        // reset two cycles with start held high: must not be accepted
        step(1'b1, '0, 1'b1);
        step(1'b1, '0, 1'b1);

        // default-length press, then let it finish
        step(1'b1, '0, 1'b0);
        run_to_done();
        idle(2);

        // short press, hold_len changed and start pulsed while busy
        step(1'b1, 20'd3, 1'b0);
        step(1'b0, 20'd9, 1'b0);
        step(1'b1, 20'd9, 1'b0);
        run_to_done();

        // start in the done cycle is accepted immediately
        step(1'b1, 20'd5, 1'b0);
        run_to_done();
        step(1'b1, '0, 1'b0);

        // reset during HOLD aborts without a done pulse
        idle(2 * G * BP + 3);
        step(1'b0, '0, 1'b1);
        idle(40);

        // random requests, lengths and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 CNT_W'($urandom_range(0, 12)),
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
